i2c_slave: RTL and testbench

I2C responder (target) that sits on the same two-wire bus as the team's I2C master and answers its transactions. It oversamples `sclk`/`sda` with the system clock and detects START/STOP. It matches a 7-bit address, ACKs, and either delivers written bytes to local logic or serialises bytes supplied by local logic. Multi-byte transfers, repeated START and master NACK are supported; clock stretching is not.

---
 rtl/i2c_slave_if.sv | 22 ++
 rtl/i2c_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: serial clock plus local-side handshake of the I2C responder.
// The open-drain sda line stays a plain inout port on the module so its
// tristate driver resolves directly on the bus wire.
interface i2c_slave_if;
  logic       sclk;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic [2:0] state;

  modport slave (
    input  sclk, tx_data,
    output rx_data, rx_valid, tx_req, busy, state
  );

  modport master (
    output sclk, tx_data,
    input  rx_data, rx_valid, tx_req, busy, state
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: I2C responder that oversamples sclk/sda with clk, detects
// START/STOP, matches a 7-bit address, and either delivers written bytes
// or serialises bytes supplied by local logic. No clock stretching.
// Optional feature: define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample
// agreement filter behind the synchronizers (+2 clk latency).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  i2c_slave_if.slave bus,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6
  } state_t;

  logic [1:0] sclk_sync;
  logic [1:0] sda_sync;
  logic       sclk_f;
  logic       sda_f;
  logic       sclk_prev;
  logic       sda_prev;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic       sda_low;
  logic       rw_q;
  logic       phase_q;
  logic       byte_done;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;
  logic       busy_q;

  // Two-flop synchronizers; idle bus level is high so reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b11;
      sda_sync  <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.sclk};
      sda_sync  <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] sclk_hist;
  logic [1:0] sda_hist;
  logic       sclk_hold;
  logic       sda_hold;

  // Keep the last two synchronized samples and the held filter output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_hist <= 2'b11;
      sda_hist  <= 2'b11;
      sclk_hold <= 1'b1;
      sda_hold  <= 1'b1;
    end else begin
      sclk_hist <= {sclk_hist[0], sclk_sync[1]};
      sda_hist  <= {sda_hist[0], sda_sync[1]};
      sclk_hold <= sclk_f;
      sda_hold  <= sda_f;
    end
  end

  assign sclk_f = (sclk_sync[1] == sclk_hist[0] && sclk_hist[0] == sclk_hist[1])
                  ? sclk_sync[1] : sclk_hold;
  assign sda_f  = (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1])
                  ? sda_sync[1] : sda_hold;
`else
  assign sclk_f = sclk_sync[1];
  assign sda_f  = sda_sync[1];
`endif

  // Previous filtered samples for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev <= 1'b1;
      sda_prev  <= 1'b1;
    end else begin
      sclk_prev <= sclk_f;
      sda_prev  <= sda_f;
    end
  end

  assign sclk_rise = sclk_f & ~sclk_prev;
  assign sclk_fall = ~sclk_f & sclk_prev;
  assign start_det = sclk_f & sda_prev & ~sda_f;
  assign stop_det  = sclk_f & ~sda_prev & sda_f;

  // Protocol FSM; START/STOP outrank bit sampling in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'h00;
      sda_low    <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      byte_done  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (tx_req_q) shift_q <= bus.tx_data;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt   <= 3'd0;
        sda_low   <= 1'b0;
        busy_q    <= 1'b0;
        phase_q   <= 1'b0;
        byte_done <= 1'b0;
      end else if (stop_det) begin
        state_q   <= IDLE;
        sda_low   <= 1'b0;
        busy_q    <= 1'b0;
        phase_q   <= 1'b0;
        byte_done <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR: begin
            if (sclk_rise) begin
              shift_q <= {shift_q[6:0], sda_f};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift_q[6:0] == SLAVE_ADDR) begin
                  state_q <= ADDR_ACK;
                  rw_q    <= sda_f;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (sclk_fall) begin
              if (!phase_q) begin
                phase_q <= 1'b1;
                sda_low <= 1'b1;
                if (rw_q) tx_req_q <= 1'b1;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                if (rw_q) begin
                  state_q <= READ;
                  sda_low <= ~shift_q[7];
                  shift_q <= {shift_q[6:0], 1'b0};
                end else begin
                  state_q <= WRITE;
                  sda_low <= 1'b0;
                end
              end
            end
          end
          WRITE: begin
            if (sclk_rise) begin
              shift_q <= {shift_q[6:0], sda_f};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data_q  <= {shift_q[6:0], sda_f};
                rx_valid_q <= 1'b1;
                byte_done  <= 1'b1;
              end
            end else if (sclk_fall && byte_done) begin
              byte_done <= 1'b0;
              state_q   <= WRITE_ACK;
              sda_low   <= 1'b1;
            end
          end
          WRITE_ACK: begin
            if (sclk_fall) begin
              sda_low <= 1'b0;
              state_q <= WRITE;
            end
          end
          READ: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end else if (sclk_fall) begin
              if (byte_done) begin
                byte_done <= 1'b0;
                sda_low   <= 1'b0;
                state_q   <= READ_ACK;
              end else begin
                sda_low <= ~shift_q[7];
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          READ_ACK: begin
            if (sclk_rise) begin
              if (!sda_f) begin
                tx_req_q <= 1'b1;
                state_q  <= READ;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                sda_low <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda          = sda_low ? 1'b0 : 1'bz;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave with directed and
// randomized transactions; expected bytes come from the bench's own data.
module tb_i2c_slave;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst;
  logic m_sda_low;
  wire  sda;

  i2c_slave_if bus();

  i2c_slave #(.SLAVE_ADDR(7'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sda (sda)
  );

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;

  logic [7:0] tx_bytes [0:3];
  int tx_pulse_cnt = 0;
  int tx_base = 0;
  int rx_pulse_cnt = 0;
  int both_cnt = 0;
  int slave_low_cnt = 0;

  // Count tx_req at the active edge so tx_data advances only after capture.
  always @(posedge clk) if (bus.tx_req) tx_pulse_cnt <= tx_pulse_cnt + 1;

  assign bus.tx_data = tx_bytes[2'(tx_pulse_cnt - tx_base)];

  // Observe strobes and slave-driven sda away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid) rx_pulse_cnt++;
    if (bus.rx_valid && bus.tx_req) both_cnt++;
    if (sda === 1'b0 && !m_sda_low) slave_low_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    waitClk(HALF/2);        m_sda_low = ~b;
    waitClk(HALF - HALF/2); bus.sclk = 1'b1;
    waitClk(HALF);          bus.sclk = 1'b0;
  endtask

  task automatic recvBit(output logic b);
    waitClk(2);             m_sda_low = 1'b0;
    waitClk(HALF - 2);      bus.sclk = 1'b1;
    waitClk(HALF/2);        b = sda;
    waitClk(HALF - HALF/2); bus.sclk = 1'b0;
  endtask

  task automatic busStart();
    waitClk(HALF/2); m_sda_low = 1'b0;
    waitClk(HALF/2); bus.sclk = 1'b1;
    waitClk(HALF/2); m_sda_low = 1'b1;
    waitClk(HALF/2); bus.sclk = 1'b0;
  endtask

  task automatic busStop();
    waitClk(HALF/2); m_sda_low = 1'b1;
    waitClk(HALF/2); bus.sclk = 1'b1;
    waitClk(HALF/2); m_sda_low = 1'b0;
    waitClk(HALF);
  endtask

  // Master writes one byte (optionally with a 2-clk sclk low glitch inside
  // the high phase of bit glitch_at) and returns the responder's ACK bit.
  task automatic applyStimulus(input logic [7:0] data, input int glitch_at,
                               output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == glitch_at) begin
        waitClk(HALF/2);        m_sda_low = ~data[i];
        waitClk(HALF - HALF/2); bus.sclk = 1'b1;
        waitClk(4);             bus.sclk = 1'b0;
        waitClk(2);             bus.sclk = 1'b1;
        waitClk(4);             bus.sclk = 1'b0;
      end else begin
        sendBit(data[i]);
      end
    end
    recvBit(ack);
  endtask

  task automatic readByte(input logic ack_in, output logic [7:0] data);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      data[i] = b;
    end
    sendBit(ack_in);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] rd;
    logic [7:0] wbyte;
    logic [6:0] bad_addr;
    int         rx0;
    int         tx0;
    int         drv0;

    rst = 1'b1;
    m_sda_low = 1'b0;
    bus.sclk = 1'b1;
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h00;
    waitClk(3);
    checkOutput("reset_state", 32'(bus.state), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 0);
    checkOutput("reset_tx_req", 32'(bus.tx_req), 0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 0);
    checkOutput("reset_sda", 32'(sda), 1);
    rst = 1'b0;
    waitClk(5);

    $display("[TB] write byte 0xA5");
    rx0 = rx_pulse_cnt;
    busStart();
    applyStimulus(8'h02, -1, ack);
    checkOutput("wr_addr_ack", 32'(ack), 0);
    checkOutput("wr_busy", 32'(bus.busy), 1);
    applyStimulus(8'hA5, -1, ack);
    checkOutput("wr_data_ack", 32'(ack), 0);
    checkOutput("wr_rx_data", 32'(bus.rx_data), 'hA5);
    checkOutput("wr_rx_pulses", 32'(rx_pulse_cnt - rx0), 1);
    busStop();
    checkOutput("wr_busy_after_stop", 32'(bus.busy), 0);
    checkOutput("wr_state_after_stop", 32'(bus.state), 0);

    $display("[TB] address mismatch");
    for (int k = 0; k < 2; k++) begin
      bad_addr = (k == 0) ? 7'h22 : 7'($urandom_range(127, 2));
      rx0 = rx_pulse_cnt;
      drv0 = slave_low_cnt;
      busStart();
      applyStimulus({bad_addr, 1'b0}, -1, ack);
      checkOutput("mm_addr_nack", 32'(ack), 1);
      checkOutput("mm_state", 32'(bus.state), 0);
      applyStimulus(8'hFF, -1, ack);
      checkOutput("mm_data_nack", 32'(ack), 1);
      busStop();
      checkOutput("mm_no_drive", 32'(slave_low_cnt - drv0), 0);
      checkOutput("mm_no_rx", 32'(rx_pulse_cnt - rx0), 0);
      checkOutput("mm_busy", 32'(bus.busy), 0);
    end

    $display("[TB] read two bytes");
    tx_bytes[0] = 8'h3C;
    tx_bytes[1] = 8'hC3;
    tx_base = tx_pulse_cnt;
    busStart();
    applyStimulus(8'h03, -1, ack);
    checkOutput("rd_addr_ack", 32'(ack), 0);
    readByte(1'b0, rd);
    checkOutput("rd_byte0", 32'(rd), 'h3C);
    checkOutput("rd_busy", 32'(bus.busy), 1);
    readByte(1'b1, rd);
    checkOutput("rd_byte1", 32'(rd), 'hC3);
    waitClk(8);
    checkOutput("rd_nack_state", 32'(bus.state), 0);
    checkOutput("rd_nack_busy", 32'(bus.busy), 0);
    checkOutput("rd_nack_sda", 32'(sda), 1);
    checkOutput("rd_tx_pulses", 32'(tx_pulse_cnt - tx_base), 2);
    busStop();

    $display("[TB] repeated start");
    tx_bytes[0] = 8'($urandom);
    wbyte = 8'($urandom);
    tx_base = tx_pulse_cnt;
    rx0 = rx_pulse_cnt;
    busStart();
    applyStimulus(8'h02, -1, ack);
    for (int i = 7; i >= 4; i--) sendBit(wbyte[i]);
    busStart();
    checkOutput("rs_state_addr", 32'(bus.state), 1);
    applyStimulus(8'h03, -1, ack);
    checkOutput("rs_addr_ack", 32'(ack), 0);
    readByte(1'b1, rd);
    checkOutput("rs_read_byte", 32'(rd), 32'(tx_bytes[0]));
    busStop();
    checkOutput("rs_no_rx", 32'(rx_pulse_cnt - rx0), 0);

    $display("[TB] randomized write/read");
    for (int n = 0; n < 3; n++) begin
      wbyte = 8'($urandom);
      rx0 = rx_pulse_cnt;
      busStart();
      applyStimulus(8'h02, -1, ack);
      applyStimulus(wbyte, -1, ack);
      checkOutput("rnd_wr_ack", 32'(ack), 0);
      checkOutput("rnd_rx_data", 32'(bus.rx_data), 32'(wbyte));
      busStop();
      checkOutput("rnd_rx_pulses", 32'(rx_pulse_cnt - rx0), 1);
      tx_bytes[0] = 8'($urandom);
      tx_bytes[1] = 8'($urandom);
      tx_base = tx_pulse_cnt;
      busStart();
      applyStimulus(8'h03, -1, ack);
      readByte(1'b0, rd);
      checkOutput("rnd_rd_byte0", 32'(rd), 32'(tx_bytes[0]));
      readByte(1'b1, rd);
      checkOutput("rnd_rd_byte1", 32'(rd), 32'(tx_bytes[1]));
      busStop();
    end

    $display("[TB] reset mid-transfer");
    tx_bytes[0] = {7'($urandom), 1'b0};
    tx_base = tx_pulse_cnt;
    busStart();
    applyStimulus(8'h03, -1, ack);
    for (int i = 7; i >= 1; i--) begin
      recvBit(b);
      rd[i] = b;
    end
    checkOutput("rst_upper_bits", 32'(rd[7:1]), 32'(tx_bytes[0][7:1]));
    waitClk(2);        m_sda_low = 1'b0;
    waitClk(HALF - 2); bus.sclk = 1'b1;
    waitClk(3);
    checkOutput("rst_pre_drive", 32'(sda), 0);
    rst = 1'b1;
    waitClk(1);
    checkOutput("rst_sda_released", 32'(sda), 1);
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_rx_data", 32'(bus.rx_data), 0);
    checkOutput("rst_strobes", 32'({bus.rx_valid, bus.tx_req}), 0);
    rst = 1'b0;
    waitClk(HALF - 4); bus.sclk = 1'b0;
    rx0 = rx_pulse_cnt;
    tx0 = tx_pulse_cnt;
    drv0 = slave_low_cnt;
    for (int i = 0; i < 9; i++) sendBit(1'($urandom));
    checkOutput("rst_ignored_state", 32'(bus.state), 0);
    checkOutput("rst_ignored_drive", 32'(slave_low_cnt - drv0), 0);
    checkOutput("rst_ignored_strobes", 32'((rx_pulse_cnt - rx0) + (tx_pulse_cnt - tx0)), 0);
    busStop();
    wbyte = 8'($urandom);
    busStart();
    applyStimulus(8'h02, -1, ack);
    checkOutput("rst_recover_ack", 32'(ack), 0);
    applyStimulus(wbyte, -1, ack);
    checkOutput("rst_recover_rx", 32'(bus.rx_data), 32'(wbyte));
    busStop();

    $display("[TB] sclk glitch");
    busStart();
    applyStimulus(8'h02, -1, ack);
    applyStimulus(8'hA5, 3, ack);
    busStop();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    checkOutput("glitch_filtered_rx", 32'(bus.rx_data), 'hA5);
`else
    checkOutput("glitch_unfiltered_rx_differs", 32'(bus.rx_data != 8'hA5), 1);
`endif

    checkOutput("strobe_overlap", 32'(both_cnt), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
